// File: rtl/xform_pkg.sv
// rtl/xform_pkg.sv - shared state encoding and sizing helpers for the transform stream controller
package xform_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } xform_state_t;

    // Coefficient beats needed to carry a full matrix.
    function automatic int calc_ncb(input int elems, input int lanes);
        return (elems + lanes - 1) / lanes;
    endfunction

    // Bits needed for a counter that must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module sync_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage array; contents need no reset because reads are gated by count.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/xform_stream_ctrl.sv
// rtl/xform_stream_ctrl.sv - coefficient loader, pipeline issue/tag tracker and output buffer
module xform_stream_ctrl
    import xform_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int LANES      = 4,
    parameter int ROWS       = 3,
    parameter int COLS       = 4,
    parameter int PIPE_LAT   = 46,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [LANES*DATA_WIDTH-1:0]       s_tdata,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    input  logic                              s_tlast,
    output logic [LANES*OUT_WIDTH-1:0]        m_tdata,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_tlast,
    output logic [ROWS*COLS*DATA_WIDTH-1:0]   coef,
    output logic                              coef_valid,
    output logic                              pipe_en,
    output logic [LANES*DATA_WIDTH-1:0]       pipe_vec,
    input  logic [LANES*OUT_WIDTH-1:0]        pipe_res,
    output logic                              frame_done,
    output logic                              err_short
);

    localparam int NELEM = ROWS * COLS;
    localparam int NCB   = calc_ncb(NELEM, LANES);
    localparam int BW    = cnt_width(NCB);
    localparam int IW    = cnt_width(PIPE_LAT);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = LANES * OUT_WIDTH + 1;

    xform_state_t              state;
    xform_state_t              state_next;
    logic [BW-1:0]             beat_cnt;
    logic                      coef_wr;
    logic                      coef_done;
    logic [PIPE_LAT-1:0]       tag_valid;
    logic [PIPE_LAT-1:0]       tag_last;
    logic [IW-1:0]             inflight;
    logic                      tag_exit;
    logic                      stream_room;
    logic [FCW-1:0]            fifo_count;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [FW-1:0]             fifo_head;
    logic                      head_last;

    assign tag_exit    = tag_valid[PIPE_LAT-1];
    // Room is reserved for every beat already in the pipeline, so the FIFO can never overflow.
    assign stream_room = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign head_last   = fifo_head[0];
    assign m_tvalid    = !fifo_empty && !areset;
    assign m_tdata     = m_tvalid ? fifo_head[FW-1:1] : '0;
    assign m_tlast     = m_tvalid && head_last;
    assign fifo_pop    = m_tvalid && m_tready;

    // Next-state and handshake decode; every output is quiet while reset is held.
    always_comb begin
        state_next = state;
        s_tready   = 1'b0;
        pipe_en    = 1'b0;
        pipe_vec   = '0;
        err_short  = 1'b0;
        frame_done = 1'b0;
        coef_wr    = 1'b0;
        coef_done  = 1'b0;
        if (!areset) begin
            case (state)
                ST_IDLE, ST_LOAD: begin
                    s_tready = 1'b1;
                    if (s_tvalid) begin
                        coef_wr = 1'b1;
                        if (s_tlast) begin
                            err_short  = 1'b1;
                            state_next = ST_IDLE;
                        end else if (beat_cnt == BW'(NCB - 1)) begin
                            coef_done  = 1'b1;
                            state_next = ST_STREAM;
                        end else begin
                            state_next = ST_LOAD;
                        end
                    end
                end
                ST_STREAM: begin
                    s_tready = stream_room;
                    if (s_tvalid && stream_room) begin
                        pipe_en  = 1'b1;
                        pipe_vec = s_tdata;
                        if (s_tlast) begin
                            state_next = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_pop && head_last) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register, coefficient beat counter and coefficient matrix capture.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            coef       <= '0;
            coef_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (coef_wr) begin
                coef_valid <= coef_done;
                if (coef_done || s_tlast) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
                // Lanes that map past the last element have no destination and fall away.
                for (int k = 0; k < NELEM; k++) begin
                    if ((k / LANES) == int'(beat_cnt)) begin
                        coef[k*DATA_WIDTH +: DATA_WIDTH] <= s_tdata[(k % LANES)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Tag shift register mirrors the compute pipeline; inflight counts set valid bits.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tag_valid <= '0;
            tag_last  <= '0;
            inflight  <= '0;
        end else begin
            tag_valid[0] <= pipe_en;
            tag_last[0]  <= pipe_en && s_tlast;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
            if (pipe_en && !tag_exit) begin
                inflight <= inflight + IW'(1);
            end else if (!pipe_en && tag_exit) begin
                inflight <= inflight - IW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (tag_exit),
        .push_data ({pipe_res, tag_last[PIPE_LAT-1]}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
